sme_job_sequencer: RTL and testbench
====================================

# sme_job_sequencer

Host-side controller that sequences the string-matching engine (SME). It buffers one string and a queue of up to NPAT patterns, then drives the engine's byte-serial `chardata`/`isstring`/`ispattern` load protocol once per pattern. The string is sent only with the first pattern of a run; the engine retains it for later patterns. Each engine `valid` pulse is captured into a tagged result presented on a ready/valid port. The block sits between the host loader and one SME instance.

## Interface
- `STR_MAX`, 32, string buffer depth in chars
- `PAT_MAX`, 8, max chars per pattern, including `^`/`$`
- `NPAT`, 4, pattern queue depth
- `TIMEOUT`, 1023, max cycles to wait for engine `valid`
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low
- `chardata`  in  8  host char for `str_we`/`pat_we`
- `str_we`  in  1  append `chardata` to string buffer
- `pat_we`  in  1  append `chardata` to current pattern
- `pat_end`  in  1  with `pat_we`: this char closes the pattern
- `start`  in  1  pulse: launch run over queued patterns
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `ovf`  out  1  sticky: a write was dropped; cleared by `start`
- `eng_chardata`  out  8  to engine `chardata`
- `eng_isstring`  out  1  to engine `isstring`
- `eng_ispattern`  out  1  to engine `ispattern`
- `eng_match`  in  1  from engine `match`
- `eng_index`  in  5  from engine `match_index`
- `eng_valid`  in  1  from engine `valid`
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_match`  out  1  match flag
- `res_index`  out  5  match index
- `res_id`  out  clog2(NPAT)  queue slot of the pattern
- `res_timeout`  out  1  engine did not answer within TIMEOUT

## Operation
- Reset drives all outputs to 0, all counters and the state to IDLE. The `str_fresh` flag resets to 0.
- States: IDLE, SEND_STR, SEND_PAT, GAP, WAIT, RESULT, NEXT.
- Host writes are accepted only in IDLE. While `busy`, writes are dropped and set `ovf`.
- String write rules:
  - The first `str_we` after reset or after a completed run clears the string count, then appends.
  - Each `str_we` sets `str_fresh`.
  - A write beyond STR_MAX chars is dropped and sets `ovf`.
- Pattern write rules:
  - `pat_we` appends to slot `pat_cnt`.
  - `pat_we` together with `pat_end` closes the slot and increments `pat_cnt`.
  - A char beyond PAT_MAX, or any write when `pat_cnt == NPAT`, is dropped and sets `ovf`.
- `start` in IDLE with `pat_cnt == 0`: pulse `done` next cycle, no engine activity.
- `start` in IDLE with `pat_cnt > 0`:
  - Set `busy` and clear `ovf`.
  - Go to SEND_STR if `str_fresh`, else SEND_PAT. Clear `str_fresh`.
- `start` outside IDLE is ignored.
- SEND_STR: one string char per cycle, `eng_isstring = 1`, for exactly the string length. Then SEND_PAT.
- SEND_PAT: one pattern char per cycle, `eng_ispattern = 1`. Then GAP.
- GAP: exactly one cycle with `eng_isstring = eng_ispattern = 0`, `eng_chardata = 0`. Then WAIT.
- WAIT: count cycles.
  - `eng_valid = 1`: latch `eng_match`/`eng_index`, set `res_timeout = 0`, go to RESULT.
  - Count reaches TIMEOUT: latch match 0, index 0, `res_timeout = 1`, go to RESULT.
- RESULT: hold `res_valid = 1` with stable fields until `res_valid && res_ready`. Then NEXT.
- NEXT: advance slot.
  - More slots remain: go to SEND_PAT (string is not resent).
  - Otherwise: clear `pat_cnt`, deassert `busy`, pulse `done`, go to IDLE.
- Engine outputs are 0 in every state except SEND_STR and SEND_PAT.
- Slots are processed in write order, 0 to `pat_cnt-1`. `res_id` equals the slot number.

## Timing
- `start` sampled at edge t: first engine char is driven in the cycle after t.
- The string and the first pattern are back-to-back with no gap. Both are contiguous, with no bubbles.
- Result timing:
  - `eng_valid` sampled high at edge e: `res_valid` is high from edge e+1.
  - `res_valid` stays high until the accepting edge. Accept at edge a: `res_valid` is low from a+1.
- After accept, NEXT takes one cycle. The next pattern's first char is at a+2. This gives ≥2 engine-idle cycles between jobs, so the engine returns to its read state.
- `done` is high for exactly one cycle, coincident with the first IDLE cycle. `busy` falls on the same edge.
- Asynchronous reset mid-run aborts immediately:
  - Outputs go to 0, the queue is emptied, `str_fresh = 0`.
  - The engine must be reset by the same reset.
- `eng_valid` outside WAIT is ignored.

## Test plan
- String "ab cd" (5 chars), pattern "^cd", `start` -> `eng_isstring` for 5 cycles, then `eng_ispattern` for 3, one gap; engine returns match 1, index 3 -> `res_match = 1`, `res_index = 3`, `res_id = 0`, then `done`.
- Three patterns "cd", "x", "b$" on the same string -> string sent once; `res_id` 0, 1, 2 in order with index 3, match 0, match 1 index 1.
- `res_ready` held low 20 cycles -> `res_valid` and all fields stable; no engine activity until accept, next pattern starts 2 cycles after accept.
- Second run with no new `str_we` and pattern "a" -> SEND_STR skipped; first engine cycle has `eng_ispattern = 1`.
- Overflow: 33 `str_we` -> `ovf = 1`, only 32 chars sent; 5 closed patterns -> 4 results; writes during `busy` dropped.
- Engine never asserts `valid` -> `res_timeout = 1`, `res_match = 0` after TIMEOUT cycles. Reset asserted mid SEND_PAT -> all outputs 0 at once, `start` then gives immediate `done` (queue empty).

Source files
------------

// File: rtl/sme_job_sequencer.sv
// Host-side job sequencer for the string-matching engine: buffers one string
// and a pattern queue, replays them byte-serially and returns tagged results.
module sme_job_sequencer #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int NPAT    = 4,
   parameter int TIMEOUT = 1023,
   localparam int IW = (NPAT > 1) ? $clog2(NPAT) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    chardata,
   input  logic          str_we,
   input  logic          pat_we,
   input  logic          pat_end,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          ovf,
   output logic [7:0]    eng_chardata,
   output logic          eng_isstring,
   output logic          eng_ispattern,
   input  logic          eng_match,
   input  logic [4:0]    eng_index,
   input  logic          eng_valid,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          res_match,
   output logic [4:0]    res_index,
   output logic [IW-1:0] res_id,
   output logic          res_timeout
);

   localparam int SW = $clog2(STR_MAX);
   localparam int SL = $clog2(STR_MAX + 1);
   localparam int PA = $clog2(PAT_MAX);
   localparam int PL = $clog2(PAT_MAX + 1);
   localparam int CW = $clog2(NPAT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int XW = (SL > PL) ? SL : PL;

   typedef enum logic [2:0] {
      IDLE, SEND_STR, SEND_PAT, GAP, WAIT, RESULT, NEXT
   } state_t;

   state_t        state;
   logic [7:0]    str_mem [STR_MAX];
   logic [7:0]    pat_mem [NPAT][PAT_MAX];
   logic [PL-1:0] pat_len [NPAT];
   logic [SL-1:0] str_len;
   logic [CW-1:0] pat_cnt;
   logic [IW-1:0] slot;
   logic [XW-1:0] idx;
   logic [TW-1:0] wcnt;
   logic          str_fresh;
   logic          str_restart;

   logic          idle;
   logic          str_full;
   logic          str_acc;
   logic          pat_acc;
   logic          drop;
   logic [SW-1:0] str_waddr;
   logic [IW-1:0] cur;
   logic [PL-1:0] cur_len;
   logic [IW-1:0] slot_nx;

   assign idle      = (state == IDLE);
   assign str_full  = !str_restart && (str_len == SL'(STR_MAX));
   assign str_acc   = str_we && idle && !str_full;
   assign str_waddr = str_restart ? '0 : str_len[SW-1:0];
   assign cur       = pat_cnt[IW-1:0];
   assign cur_len   = pat_len[cur];
   assign pat_acc   = pat_we && idle && (pat_cnt < CW'(NPAT))
                      && (cur_len != PL'(PAT_MAX));
   assign drop      = (str_we && !str_acc) || (pat_we && !pat_acc);
   assign slot_nx   = slot + IW'(1);

   // Buffers need no reset; their valid extent lives in the counters.
   always_ff @(posedge clk) begin
      if (str_acc) str_mem[str_waddr] <= chardata;
      if (pat_acc) pat_mem[cur][cur_len[PA-1:0]] <= chardata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         ovf           <= 1'b0;
         eng_chardata  <= '0;
         eng_isstring  <= 1'b0;
         eng_ispattern <= 1'b0;
         res_valid     <= 1'b0;
         res_match     <= 1'b0;
         res_index     <= '0;
         res_id        <= '0;
         res_timeout   <= 1'b0;
         str_len       <= '0;
         pat_cnt       <= '0;
         slot          <= '0;
         idx           <= '0;
         wcnt          <= '0;
         str_fresh     <= 1'b0;
         str_restart   <= 1'b1;
         for (int i = 0; i < NPAT; i++) pat_len[i] <= '0;
      end else begin
         done <= 1'b0;
         if (str_acc) begin
            str_len     <= str_restart ? SL'(1) : str_len + SL'(1);
            str_restart <= 1'b0;
         end
         if (str_we && idle) str_fresh <= 1'b1;
         if (pat_acc) begin
            pat_len[cur] <= cur_len + PL'(1);
            if (pat_end) pat_cnt <= pat_cnt + CW'(1);
         end
         if (drop) ovf <= 1'b1;

         unique case (state)
            IDLE: begin
               if (start) begin
                  if (pat_cnt == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy      <= 1'b1;
                     ovf       <= 1'b0;
                     str_fresh <= 1'b0;
                     slot      <= '0;
                     idx       <= XW'(1);
                     if (str_fresh) begin
                        state        <= SEND_STR;
                        eng_isstring <= 1'b1;
                        eng_chardata <= str_mem[0];
                     end else begin
                        state         <= SEND_PAT;
                        eng_ispattern <= 1'b1;
                        eng_chardata  <= pat_mem[0][0];
                     end
                  end
               end
            end
            SEND_STR: begin
               if (idx == XW'(str_len)) begin
                  state         <= SEND_PAT;
                  eng_isstring  <= 1'b0;
                  eng_ispattern <= 1'b1;
                  eng_chardata  <= pat_mem[slot][0];
                  idx           <= XW'(1);
               end else begin
                  eng_chardata <= str_mem[idx[SW-1:0]];
                  idx          <= idx + XW'(1);
               end
            end
            SEND_PAT: begin
               if (idx == XW'(pat_len[slot])) begin
                  state         <= GAP;
                  eng_ispattern <= 1'b0;
                  eng_chardata  <= '0;
               end else begin
                  eng_chardata <= pat_mem[slot][idx[PA-1:0]];
                  idx          <= idx + XW'(1);
               end
            end
            GAP: begin
               state <= WAIT;
               wcnt  <= '0;
            end
            WAIT: begin
               if (eng_valid) begin
                  state       <= RESULT;
                  res_valid   <= 1'b1;
                  res_match   <= eng_match;
                  res_index   <= eng_index;
                  res_id      <= slot;
                  res_timeout <= 1'b0;
               end else if (wcnt == TW'(TIMEOUT - 1)) begin
                  state       <= RESULT;
                  res_valid   <= 1'b1;
                  res_match   <= 1'b0;
                  res_index   <= '0;
                  res_id      <= slot;
                  res_timeout <= 1'b1;
               end else begin
                  wcnt <= wcnt + TW'(1);
               end
            end
            RESULT: begin
               if (res_ready) begin
                  state     <= NEXT;
                  res_valid <= 1'b0;
               end
            end
            NEXT: begin
               // Next job starts here so the engine sees exactly one idle
               // cycle after the accept, on top of the gap and wait time.
               if ((CW'(slot) + CW'(1)) < pat_cnt) begin
                  state         <= SEND_PAT;
                  slot          <= slot_nx;
                  eng_ispattern <= 1'b1;
                  eng_chardata  <= pat_mem[slot_nx][0];
                  idx           <= XW'(1);
               end else begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  pat_cnt     <= '0;
                  str_restart <= 1'b1;
                  for (int i = 0; i < NPAT; i++) pat_len[i] <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sme_job_sequencer.sv
// Scoreboard bench for sme_job_sequencer: directed jobs, a scripted engine
// responder, and a monitor that checks every accepted result in order.
module tb_sme_job_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] chardata;
   logic       str_we, pat_we, pat_end, start;
   logic       busy, done, ovf;
   logic [7:0] eng_chardata;
   logic       eng_isstring, eng_ispattern;
   logic       eng_match, eng_valid;
   logic [4:0] eng_index;
   logic       res_valid, res_ready, res_match, res_timeout;
   logic [4:0] res_index;
   logic [1:0] res_id;

   sme_job_sequencer dut (
      .clk(clk), .reset(reset), .chardata(chardata),
      .str_we(str_we), .pat_we(pat_we), .pat_end(pat_end),
      .start(start), .busy(busy), .done(done), .ovf(ovf),
      .eng_chardata(eng_chardata), .eng_isstring(eng_isstring),
      .eng_ispattern(eng_ispattern), .eng_match(eng_match),
      .eng_index(eng_index), .eng_valid(eng_valid),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_match(res_match), .res_index(res_index),
      .res_id(res_id), .res_timeout(res_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       m;
      logic [4:0] idx;
      int         dly;
   } eng_t;

   eng_t       eng_q[$];
   logic [8:0] exp_q[$];
   int         n_tests = 0;
   int         n_fail = 0;
   string      trace = "";
   logic [1:0] prev_m = 2'b00;
   logic       was_pat = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_trace(input string name, input string exp);
      n_tests++;
      if (trace != exp) begin
         n_fail++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, trace, exp);
      end
   endtask

   // dly = -1 means the engine never answers for that job.
   task automatic job(input logic m, input logic [4:0] idx,
                      input logic [1:0] id, input logic to, input int dly);
      eng_t e;
      e.m = m; e.idx = idx; e.dly = dly;
      eng_q.push_back(e);
      exp_q.push_back({m & !to, to ? 5'd0 : idx, id, to});
   endtask

   task automatic put_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         chardata = s[i];
         str_we = 1'b1;
         tick();
      end
      str_we = 1'b0;
   endtask

   task automatic put_pat(input string s);
      for (int i = 0; i < s.len(); i++) begin
         chardata = s[i];
         pat_we = 1'b1;
         pat_end = (i == s.len() - 1);
         tick();
      end
      pat_we = 1'b0;
      pat_end = 1'b0;
   endtask

   task automatic start_run(input string name, input logic [1:0] mode);
      trace = "";
      start = 1'b1;
      tick();
      start = 1'b0;
      check(name, {30'd0, eng_isstring, eng_ispattern}, {30'd0, mode});
   endtask

   task automatic wait_done(input string name);
      int c = 0;
      while (!done && c < 5000) begin
         tick();
         c++;
      end
      check(name, {31'd0, done}, 32'd1);
   endtask

   // Engine activity trace: '/' string->pattern, '|' end of pattern,
   // '#' string followed by a bubble, '!' both strobes, '?' stray data.
   always @(negedge clk) begin
      logic [1:0] m;
      m = {eng_isstring, eng_ispattern};
      if (m == 2'b11) trace = {trace, "!"};
      if (prev_m == 2'b10 && m == 2'b01) trace = {trace, "/"};
      if (prev_m == 2'b10 && m == 2'b00) trace = {trace, "#"};
      if (prev_m == 2'b01 && m == 2'b00) trace = {trace, "|"};
      if (m != 2'b00) trace = $sformatf("%s%c", trace, eng_chardata);
      else if (eng_chardata != 8'd0) trace = {trace, "?"};
      prev_m = m;
   end

   // Scripted engine: answers each job a few cycles after its gap cycle.
   initial begin
      eng_t r;
      eng_valid = 1'b0;
      eng_match = 1'b0;
      eng_index = '0;
      forever begin
         @(negedge clk);
         if (was_pat && !eng_ispattern && reset && eng_q.size() > 0) begin
            r = eng_q.pop_front();
            if (r.dly >= 0) begin
               repeat (r.dly) @(negedge clk);
               eng_match = r.m;
               eng_index = r.idx;
               eng_valid = 1'b1;
               @(negedge clk);
               eng_valid = 1'b0;
               eng_match = 1'b0;
               eng_index = '0;
            end
         end
         was_pat = eng_ispattern;
      end
   end

   always @(negedge clk) begin
      logic [8:0] got, e;
      if (reset && res_valid && res_ready) begin
         got = {res_match, res_index, res_id, res_timeout};
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL result_extra: got %h expected none", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL result: got %h expected %h", got, e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [8:0] snap;
      logic       ok;
      int         c;
      reset = 1'b0;
      chardata = '0;
      str_we = 1'b0;
      pat_we = 1'b0;
      pat_end = 1'b0;
      start = 1'b0;
      res_ready = 1'b1;
      repeat (3) tick();
      check("reset_outputs",
            {9'd0, busy, done, ovf, eng_chardata, eng_isstring,
             eng_ispattern, res_valid, res_match, res_index, res_id,
             res_timeout}, 32'd0);
      reset = 1'b1;
      tick();

      // Single job with string.
      put_str("ab cd");
      put_pat("^cd");
      job(1'b1, 5'd3, 2'd0, 1'b0, 2);
      start_run("t1_first_is_string", 2'b10);
      check("t1_busy", {31'd0, busy}, 32'd1);
      wait_done("t1_done");
      check_trace("t1_trace", "ab cd/^cd|");
      tick();
      check("t1_done_pulse", {30'd0, done, busy}, 32'd0);

      // Three jobs, string sent once.
      put_str("ab cd");
      put_pat("cd");
      put_pat("x");
      put_pat("b$");
      job(1'b1, 5'd3, 2'd0, 1'b0, 2);
      job(1'b0, 5'd0, 2'd1, 1'b0, 3);
      job(1'b1, 5'd1, 2'd2, 1'b0, 1);
      start_run("t2_first_is_string", 2'b10);
      wait_done("t2_done");
      check_trace("t2_trace", "ab cd/cd|x|b$|");

      // Back-pressure on the result port.
      put_pat("ab");
      put_pat("c");
      job(1'b1, 5'd1, 2'd0, 1'b0, 2);
      job(1'b0, 5'd0, 2'd1, 1'b0, 3);
      res_ready = 1'b0;
      start_run("t3_first_is_pattern", 2'b01);
      c = 0;
      while (!res_valid && c < 200) begin
         tick();
         c++;
      end
      check("t3_res_valid", {31'd0, res_valid}, 32'd1);
      snap = {res_match, res_index, res_id, res_timeout};
      ok = 1'b1;
      repeat (20) begin
         tick();
         if (!res_valid || eng_isstring || eng_ispattern ||
             {res_match, res_index, res_id, res_timeout} != snap)
            ok = 1'b0;
      end
      check("t3_stable", {31'd0, ok}, 32'd1);
      res_ready = 1'b1;
      tick();
      check("t3_after_accept", {30'd0, res_valid, eng_ispattern}, 32'd0);
      tick();
      check("t3_next_char", {23'd0, eng_ispattern, eng_chardata},
            {23'd0, 1'b1, 8'h63});
      wait_done("t3_done");
      check_trace("t3_trace", "ab|c|");

      // No new string: SEND_STR skipped.
      put_pat("a");
      job(1'b1, 5'd0, 2'd0, 1'b0, 1);
      start_run("t4_first_is_pattern", 2'b01);
      wait_done("t4_done");
      check_trace("t4_trace", "a|");

      // Overflow cases.
      put_str("0123456789abcdefghijklmnopqrstuvw");
      check("t5_str_ovf", {31'd0, ovf}, 32'd1);
      put_pat("p");
      put_pat("q");
      put_pat("r");
      put_pat("s");
      put_pat("t");
      job(1'b0, 5'd0, 2'd0, 1'b0, 1);
      job(1'b1, 5'd2, 2'd1, 1'b0, 1);
      job(1'b0, 5'd0, 2'd2, 1'b0, 1);
      job(1'b1, 5'd31, 2'd3, 1'b0, 1);
      start_run("t5_first_is_string", 2'b10);
      check("t5_ovf_cleared", {31'd0, ovf}, 32'd0);
      chardata = "w";
      pat_we = 1'b1;
      pat_end = 1'b1;
      tick();
      pat_we = 1'b0;
      pat_end = 1'b0;
      check("t5_busy_write_ovf", {31'd0, ovf}, 32'd1);
      wait_done("t5_done");
      check_trace("t5_trace", "0123456789abcdefghijklmnopqrstuv/p|q|r|s|");
      put_pat("z");
      job(1'b1, 5'd4, 2'd0, 1'b0, 1);
      start_run("t5b_first_is_pattern", 2'b01);
      wait_done("t5b_done");
      check_trace("t5b_trace", "z|");

      // Engine never answers.
      put_pat("k");
      job(1'b1, 5'd7, 2'd0, 1'b1, -1);
      start_run("t6_first_is_pattern", 2'b01);
      wait_done("t6_done");

      // Reset in the middle of a pattern.
      put_str("xy");
      put_pat("hello");
      start_run("t7_first_is_string", 2'b10);
      c = 0;
      while (!eng_ispattern && c < 50) begin
         tick();
         c++;
      end
      tick();
      reset = 1'b0;
      #1;
      check("t7_reset_outputs",
            {9'd0, busy, done, ovf, eng_chardata, eng_isstring,
             eng_ispattern, res_valid, res_match, res_index, res_id,
             res_timeout}, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t7_empty_done", {30'd0, done, busy}, 32'd2);
      put_pat("q");
      job(1'b0, 5'd0, 2'd0, 1'b0, 1);
      start_run("t7_no_fresh_string", 2'b01);
      wait_done("t7_done");

      repeat (3) tick();
      check("results_drained", exp_q.size(), 32'd0);
      check("engine_drained", eng_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
